spi_flash_responder: RTL and testbench

- Synthesizable SPI flash target model: the responder end of the extended-SPI link driven by our SPI PHY master.
- Decodes command, address and dummy on DQ0, returns data on DQ[3:0] (1-1-4 read) or on DQ1 (status/ID), and accepts quad program data.
- Backed by a small internal byte memory with a backdoor port.
- Used for on-chip loopback and for bench-level verification of the PHY and the UART programming path without real silicon.

---
 rtl/spi_flash_pkg.sv | 39 +++
 rtl/spi_flash_mem.sv | 38 +++
 rtl/spi_flash_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status-register bit positions and FSM states for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_QOFR = 8'h6B;
    localparam logic [7:0] CMD_QIFP = 8'h32;
    localparam logic [7:0] CMD_SSE  = 8'h20;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    localparam int SUBSECTOR_AW = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_QREAD,
        ST_PROG,
        ST_STAT,
        ST_ID,
        ST_IGNORE
    } state_e;

    function automatic logic opcode_known(input logic [7:0] op);
        case (op)
            CMD_WREN, CMD_WRDI, CMD_RDSR, CMD_RDID, CMD_QOFR, CMD_QIFP: return 1'b1;
`ifdef SPI_RESP_ERASE_EN
            CMD_SSE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Byte RAM shared by the SPI engine and a backdoor port; SPI writes win a same-clk collision.
module spi_flash_mem #(
    parameter int MEM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_we,
    input  logic [MEM_AW-1:0] spi_waddr,
    input  logic [7:0]        spi_wdata,
    input  logic [MEM_AW-1:0] spi_raddr,
    output logic [7:0]        spi_rdata,
    input  logic              bd_we,
    input  logic [MEM_AW-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
);

    logic [7:0]        mem [2**MEM_AW];
    logic              we;
    logic [MEM_AW-1:0] waddr;
    logic [7:0]        wdata;

    assign we    = spi_we | bd_we;
    assign waddr = spi_we ? spi_waddr : bd_addr;
    assign wdata = spi_we ? spi_wdata : bd_wdata;

    // NOTE: the array has no reset so it maps onto RAM; only the read-out register is reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        spi_rdata <= mem[spi_raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bd_rdata <= '0;
        else     bd_rdata <= mem[bd_addr];
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target: status/ID on DQ1, 1-1-4 quad read, quad page program, backdoor RAM access.
// Define SPI_RESP_ERASE_EN to add the 0x20 4 KB subsector erase.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_BITS    = 24,
    parameter int          MEM_AW       = 13,
    parameter int          DUMMY_CYCLES = 10,
    parameter int          PROG_LATENCY = 64,
    parameter logic [23:0] ID_WORD      = 24'h20BB19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              cs_n_in,
    input  logic [3:0]        dq_in,
    output logic [3:0]        dq_out,
    output logic [3:0]        dq_oe,
    output logic              cmd_strobe,
    output logic [7:0]        cmd_code,
    output logic              cmd_err,
    input  logic              bd_we,
    input  logic [MEM_AW-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
);

    localparam int              WIP_W      = 16;
    localparam logic [5:0]      ADDR_LAST  = 6'(ADDR_BITS - 1);
    localparam logic [5:0]      DUMMY_LAST = 6'(DUMMY_CYCLES - 1);
    localparam logic [WIP_W-1:0] PROG_WIP  = WIP_W'(PROG_LATENCY - 1);

    state_e            state, state_nxt;
    logic              sclk_q, rise, fall;
    logic [5:0]        bit_cnt;
    logic [6:0]        cmd_sr;
    logic [7:0]        op;
    logic [MEM_AW-1:0] addr_sr, addr_in, ptr;
    logic [4:0]        out_idx;
    logic              nib_hi;
    logic [3:0]        prog_hi;
    logic              wel, wip, prog_written;
    logic [WIP_W-1:0]  wip_cnt;
    logic              cmd_done, addr_done, dummy_done;
    logic [7:0]        stat_byte;
    logic [3:0]        dq_nxt, oe_nxt;
    logic              spi_we;
    logic [MEM_AW-1:0] spi_waddr;
    logic [7:0]        spi_wdata, spi_rdata;

`ifdef SPI_RESP_ERASE_EN
    localparam logic [WIP_W-1:0] ERASE_WIP = WIP_W'(2**SUBSECTOR_AW + PROG_LATENCY - 1);
    logic                           erase_busy;
    logic [SUBSECTOR_AW-1:0]        erase_cnt;
    logic [MEM_AW-SUBSECTOR_AW-1:0] erase_base;
`endif

    assign rise       = sclk_in & ~sclk_q;
    assign fall       = ~sclk_in & sclk_q;
    assign op         = {cmd_sr, dq_in[0]};
    assign addr_in    = {addr_sr[MEM_AW-2:0], dq_in[0]};
    assign cmd_done   = !cs_n_in && rise && state == ST_CMD   && bit_cnt == 6'd7;
    assign addr_done  = !cs_n_in && rise && state == ST_ADDR  && bit_cnt == ADDR_LAST;
    assign dummy_done = !cs_n_in && rise && state == ST_DUMMY && bit_cnt == DUMMY_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_CMD;
                ST_CMD: if (cmd_done) begin
                    if (wip && op != CMD_RDSR) state_nxt = ST_IGNORE;
                    else begin
                        case (op)
                            CMD_WREN, CMD_WRDI: state_nxt = ST_IDLE;
                            CMD_RDSR:           state_nxt = ST_STAT;
                            CMD_RDID:           state_nxt = ST_ID;
                            CMD_QOFR, CMD_QIFP: state_nxt = ST_ADDR;
`ifdef SPI_RESP_ERASE_EN
                            CMD_SSE:            state_nxt = wel ? ST_ADDR : ST_IGNORE;
`endif
                            default:            state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: if (addr_done) begin
                    if (cmd_code == CMD_QOFR) state_nxt = ST_DUMMY;
`ifdef SPI_RESP_ERASE_EN
                    else if (cmd_code == CMD_SSE) state_nxt = ST_IGNORE;
`endif
                    else state_nxt = ST_PROG;
                end
                ST_DUMMY: if (dummy_done) state_nxt = ST_QREAD;
                default: ;
            endcase
        end
    end

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        stat_byte         = '0;
        stat_byte[SR_WEL] = wel;
        stat_byte[SR_WIP] = wip;
        dq_nxt    = dq_out;
        oe_nxt    = dq_oe;
        spi_we    = 1'b0;
        spi_waddr = ptr;
        spi_wdata = spi_rdata & {prog_hi, dq_in};
        if (cs_n_in) begin
            dq_nxt = '0;
            oe_nxt = '0;
        end else if (fall) begin
            dq_nxt = '0;
            oe_nxt = '0;
            case (state)
                ST_STAT: begin
                    oe_nxt    = 4'b0010;
                    dq_nxt[1] = stat_byte[3'd7 - out_idx[2:0]];
                end
                ST_ID: begin
                    oe_nxt    = 4'b0010;
                    dq_nxt[1] = ID_WORD[5'd23 - out_idx];
                end
                ST_QREAD: begin
                    oe_nxt = 4'hF;
                    dq_nxt = nib_hi ? spi_rdata[7:4] : spi_rdata[3:0];
                end
                default: ;
            endcase
        end
        if (!cs_n_in && rise && state == ST_PROG && !nib_hi && wel) spi_we = 1'b1;
`ifdef SPI_RESP_ERASE_EN
        if (erase_busy) begin
            spi_we    = 1'b1;
            spi_waddr = {erase_base, erase_cnt};
            spi_wdata = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q       <= 1'b0;
            dq_out       <= '0;
            dq_oe        <= '0;
            cmd_strobe   <= 1'b0;
            cmd_code     <= '0;
            cmd_err      <= 1'b0;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            addr_sr      <= '0;
            ptr          <= '0;
            out_idx      <= '0;
            nib_hi       <= 1'b1;
            prog_hi      <= '0;
            wel          <= 1'b0;
            wip          <= 1'b0;
            wip_cnt      <= '0;
            prog_written <= 1'b0;
`ifdef SPI_RESP_ERASE_EN
            erase_busy   <= 1'b0;
            erase_cnt    <= '0;
            erase_base   <= '0;
`endif
        end else begin
            sclk_q     <= sclk_in;
            dq_out     <= dq_nxt;
            dq_oe      <= oe_nxt;
            cmd_strobe <= cmd_done;
            if (wip) begin
                if (wip_cnt == '0) wip <= 1'b0;
                else               wip_cnt <= wip_cnt - 1'b1;
            end
`ifdef SPI_RESP_ERASE_EN
            if (erase_busy) begin
                erase_cnt <= erase_cnt + 1'b1;
                if (&erase_cnt) begin
                    erase_busy <= 1'b0;
                    wel        <= 1'b0;
                end
            end
`endif
            if (cs_n_in) begin
                bit_cnt <= '0;
                out_idx <= '0;
                nib_hi  <= 1'b1;
                if (prog_written) begin
                    prog_written <= 1'b0;
                    wel          <= 1'b0;
                    wip          <= 1'b1;
                    wip_cnt      <= PROG_WIP;
                end
            end else begin
                if (rise) begin
                    case (state)
                        ST_CMD: begin
                            cmd_sr  <= op[6:0];
                            bit_cnt <= cmd_done ? 6'd0 : bit_cnt + 6'd1;
                            if (cmd_done) begin
                                cmd_code <= op;
                                if (!opcode_known(op))        cmd_err <= 1'b1;
                                if (!wip && op == CMD_WREN)   wel     <= 1'b1;
                                if (!wip && op == CMD_WRDI)   wel     <= 1'b0;
                            end
                        end
                        ST_ADDR: begin
                            addr_sr <= addr_in;
                            bit_cnt <= addr_done ? 6'd0 : bit_cnt + 6'd1;
                            if (addr_done) ptr <= addr_in;
`ifdef SPI_RESP_ERASE_EN
                            if (addr_done && cmd_code == CMD_SSE) begin
                                erase_busy <= 1'b1;
                                erase_cnt  <= '0;
                                erase_base <= addr_in[MEM_AW-1:SUBSECTOR_AW];
                                wip        <= 1'b1;
                                wip_cnt    <= ERASE_WIP;
                            end
`endif
                        end
                        ST_DUMMY: bit_cnt <= dummy_done ? 6'd0 : bit_cnt + 6'd1;
                        ST_PROG: begin
                            if (nib_hi) begin
                                prog_hi <= dq_in;
                                nib_hi  <= 1'b0;
                            end else begin
                                nib_hi <= 1'b1;
                                // page program wraps inside the 256-byte page
                                ptr    <= {ptr[MEM_AW-1:8], ptr[7:0] + 8'd1};
                                if (wel) prog_written <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (fall) begin
                    case (state)
                        ST_STAT: out_idx <= (out_idx == 5'd7)  ? 5'd0 : out_idx + 5'd1;
                        ST_ID:   out_idx <= (out_idx == 5'd23) ? 5'd0 : out_idx + 5'd1;
                        ST_QREAD: begin
                            nib_hi <= !nib_hi;
                            if (!nib_hi) ptr <= ptr + MEM_AW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    spi_flash_mem #(.MEM_AW(MEM_AW)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .spi_we    (spi_we),
        .spi_waddr (spi_waddr),
        .spi_wdata (spi_wdata),
        .spi_raddr (ptr),
        .spi_rdata (spi_rdata),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata)
    );

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: status, ID, quad read, page program, error and abort cases.
module tb_spi_flash_responder;

    localparam int MEM_AW = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk_in, cs_n_in;
    logic [3:0]        dq_in;
    logic [3:0]        dq_out, dq_oe;
    logic              cmd_strobe, cmd_err;
    logic [7:0]        cmd_code;
    logic              bd_we;
    logic [MEM_AW-1:0] bd_addr;
    logic [7:0]        bd_wdata, bd_rdata;

    int checks   = 0;
    int failures = 0;

    spi_flash_responder dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_in    (sclk_in),
        .cs_n_in    (cs_n_in),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .cmd_strobe (cmd_strobe),
        .cmd_code   (cmd_code),
        .cmd_err    (cmd_err),
        .bd_we      (bd_we),
        .bd_addr    (bd_addr),
        .bd_wdata   (bd_wdata),
        .bd_rdata   (bd_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One SCLK period: falling half drives dq_in, outputs are sampled just before the rise.
    task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        @(negedge clk); sclk_in = 1'b0; dq_in = d;
        @(negedge clk); q = dq_out; oe = dq_oe; sclk_in = 1'b1;
    endtask

    task automatic cs_low;
        @(negedge clk); cs_n_in = 1'b0; sclk_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_high;
        @(negedge clk); cs_n_in = 1'b1; sclk_in = 1'b0; dq_in = '0;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b, output logic stb);
        logic [3:0] q, oe;
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b0, b[i]}, q, oe);
        @(negedge clk); stb = cmd_strobe;
    endtask

    task automatic send_addr(input logic [31:0] a, input int n);
        logic [3:0] q, oe;
        for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b0, a[i]}, q, oe);
    endtask

    task automatic send_data(input logic [7:0] b);
        logic [3:0] q, oe;
        sclk_cycle(b[7:4], q, oe);
        sclk_cycle(b[3:0], q, oe);
    endtask

    // quad=0: shifts dq_out[1] per cycle; quad=1: shifts whole nibbles.
    task automatic read_seq(input int n, input bit quad, output logic [31:0] v,
                            output logic [3:0] oe_or, output logic [3:0] oe_and);
        logic [3:0] q, oe;
        v = '0; oe_or = '0; oe_and = 4'hF;
        for (int i = 0; i < n; i++) begin
            sclk_cycle(4'h0, q, oe);
            v      = quad ? {v[27:0], q} : {v[30:0], q[1]};
            oe_or  = oe_or | oe;
            oe_and = oe_and & oe;
        end
    endtask

    task automatic status_read(output logic [7:0] s, output logic [3:0] oe_and);
        logic        stb;
        logic [31:0] v;
        logic [3:0]  oe_or;
        cs_low;
        send_cmd(8'h05, stb);
        read_seq(8, 1'b0, v, oe_or, oe_and);
        s = v[7:0];
        cs_high;
    endtask

    task automatic bd_write(input logic [MEM_AW-1:0] a, input logic [7:0] d);
        @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(negedge clk); bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [MEM_AW-1:0] a, output logic [7:0] d);
        @(negedge clk); bd_addr = a;
        @(negedge clk); d = bd_rdata;
    endtask

    task automatic test_reset;
        rst = 1'b1; sclk_in = 1'b0; cs_n_in = 1'b1; dq_in = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (dq_oe !== 4'h0) begin failures++; $display("FAIL reset_oe got=%h exp=0", dq_oe); end
        checks++; if (dq_out !== 4'h0) begin failures++; $display("FAIL reset_dq got=%h exp=0", dq_out); end
        checks++; if (cmd_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", cmd_strobe); end
        checks++; if (cmd_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", cmd_code); end
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
        checks++; if (bd_rdata !== 8'h00) begin failures++; $display("FAIL reset_bd_rdata got=%h exp=00", bd_rdata); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_status;
        logic        stb;
        logic [31:0] v;
        logic [3:0]  oe_or, oe_and;
        cs_low;
        send_cmd(8'h05, stb);
        checks++; if (stb !== 1'b1) begin failures++; $display("FAIL rdsr_strobe got=%b exp=1", stb); end
        checks++; if (cmd_code !== 8'h05) begin failures++; $display("FAIL rdsr_code got=%h exp=05", cmd_code); end
        read_seq(16, 1'b0, v, oe_or, oe_and);
        checks++; if (v[15:0] !== 16'h0000) begin failures++; $display("FAIL rdsr_value got=%h exp=0000", v[15:0]); end
        checks++; if (oe_or !== 4'b0010 || oe_and !== 4'b0010) begin
            failures++; $display("FAIL rdsr_oe got_or=%b got_and=%b exp=0010", oe_or, oe_and);
        end
        cs_high;
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL rdsr_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_id;
        logic        stb;
        logic [31:0] v;
        logic [3:0]  oe_or, oe_and;
        cs_low;
        send_cmd(8'h9F, stb);
        read_seq(24, 1'b0, v, oe_or, oe_and);
        checks++; if (v[23:0] !== 24'h20BB19) begin failures++; $display("FAIL rdid_first got=%h exp=20bb19", v[23:0]); end
        checks++; if (oe_and !== 4'b0010) begin failures++; $display("FAIL rdid_oe got=%b exp=0010", oe_and); end
        read_seq(24, 1'b0, v, oe_or, oe_and);
        checks++; if (v[23:0] !== 24'h20BB19) begin failures++; $display("FAIL rdid_repeat got=%h exp=20bb19", v[23:0]); end
        cs_high;
    endtask

    task automatic test_qread;
        logic        stb;
        logic [31:0] v;
        logic [3:0]  oe_or, oe_and;
        bd_write(13'h0100, 8'h11);
        bd_write(13'h0101, 8'h22);
        bd_write(13'h0102, 8'h33);
        bd_write(13'h0103, 8'h44);
        cs_low;
        send_cmd(8'h6B, stb);
        send_addr(32'h000100, 24);
        read_seq(10, 1'b1, v, oe_or, oe_and);
        checks++; if (oe_or !== 4'h0) begin failures++; $display("FAIL qread_dummy_oe got=%b exp=0000", oe_or); end
        read_seq(8, 1'b1, v, oe_or, oe_and);
        checks++; if (v !== 32'h11223344) begin failures++; $display("FAIL qread_data got=%h exp=11223344", v); end
        checks++; if (oe_and !== 4'hF) begin failures++; $display("FAIL qread_oe got=%b exp=1111", oe_and); end
        cs_high;
        // 0x00FFFF folds onto the last memory byte, then the read wraps to 0
        bd_write(13'h1FFF, 8'h9A);
        bd_write(13'h0000, 8'hBC);
        cs_low;
        send_cmd(8'h6B, stb);
        send_addr(32'h00FFFF, 24);
        read_seq(10, 1'b1, v, oe_or, oe_and);
        read_seq(4, 1'b1, v, oe_or, oe_and);
        checks++; if (v[15:0] !== 16'h9ABC) begin failures++; $display("FAIL qread_wrap got=%h exp=9abc", v[15:0]); end
        cs_high;
    endtask

    task automatic test_program;
        logic       stb;
        logic [7:0] s, d;
        logic [3:0] oe_and;
        bd_write(13'h01FE, 8'hFF);
        bd_write(13'h01FF, 8'hFF);
        bd_write(13'h0100, 8'hFF);
        cs_low; send_cmd(8'h06, stb); cs_high;
        status_read(s, oe_and);
        checks++; if (s !== 8'h02) begin failures++; $display("FAIL wren_status got=%h exp=02", s); end
        cs_low;
        send_cmd(8'h32, stb);
        send_addr(32'h0001FE, 24);
        send_data(8'hA5);
        send_data(8'h5A);
        send_data(8'h0F);
        cs_high;
        status_read(s, oe_and);
        checks++; if (s !== 8'h01) begin failures++; $display("FAIL prog_busy_status got=%h exp=01", s); end
        repeat (80) @(negedge clk);
        status_read(s, oe_and);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL prog_done_status got=%h exp=00", s); end
        bd_read(13'h01FE, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL prog_mem_1fe got=%h exp=a5", d); end
        bd_read(13'h01FF, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL prog_mem_1ff got=%h exp=5a", d); end
        bd_read(13'h0100, d);
        checks++; if (d !== 8'h0F) begin failures++; $display("FAIL prog_mem_100 got=%h exp=0f", d); end
        bd_read(13'h0101, d);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL prog_mem_101 got=%h exp=22", d); end
    endtask

    task automatic test_prog_no_wel;
        logic       stb;
        logic [7:0] s, d;
        logic [3:0] oe_and;
        bd_write(13'h0300, 8'h3C);
        cs_low;
        send_cmd(8'h32, stb);
        send_addr(32'h000300, 24);
        send_data(8'h00);
        cs_high;
        repeat (4) @(negedge clk);
        bd_read(13'h0300, d);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL nowel_mem got=%h exp=3c", d); end
        status_read(s, oe_and);
        checks++; if (s !== 8'h00) begin failures++; $display("FAIL nowel_status got=%h exp=00", s); end
    endtask

    task automatic test_bad_opcode;
        logic        stb;
        logic [31:0] v;
        logic [3:0]  oe_or, oe_and;
        cs_low;
        send_cmd(8'hAB, stb);
        checks++; if (cmd_code !== 8'hAB) begin failures++; $display("FAIL bad_code got=%h exp=ab", cmd_code); end
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", cmd_err); end
        read_seq(8, 1'b0, v, oe_or, oe_and);
        checks++; if (oe_or !== 4'h0) begin failures++; $display("FAIL bad_no_drive got=%b exp=0000", oe_or); end
        cs_high;
        checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL bad_err_sticky got=%b exp=1", cmd_err); end
    endtask

    task automatic test_abort;
        logic        stb;
        logic [31:0] v;
        logic [7:0]  s;
        logic [3:0]  oe_or, oe_and;
        cs_low;
        send_cmd(8'h9F, stb);
        read_seq(4, 1'b0, v, oe_or, oe_and);
        checks++; if (v[3:0] !== 4'h2 || oe_and !== 4'b0010) begin
            failures++; $display("FAIL abort_id_partial got=%h/%b exp=2/0010", v[3:0], oe_and);
        end
        cs_high;
        checks++; if (dq_oe !== 4'h0) begin failures++; $display("FAIL abort_id_oe got=%b exp=0000", dq_oe); end
        cs_low;
        send_cmd(8'h6B, stb);
        send_addr(32'h000100 >> 12, 12);
        cs_high;
        checks++; if (dq_oe !== 4'h0) begin failures++; $display("FAIL abort_addr_oe got=%b exp=0000", dq_oe); end
        status_read(s, oe_and);
        checks++; if (cmd_code !== 8'h05) begin failures++; $display("FAIL abort_next_code got=%h exp=05", cmd_code); end
        checks++; if (s !== 8'h00 || oe_and !== 4'b0010) begin
            failures++; $display("FAIL abort_next_status got=%h/%b exp=00/0010", s, oe_and);
        end
    endtask

    initial begin
        test_reset;
        test_status;
        test_id;
        test_qread;
        test_program;
        test_prog_no_wel;
        test_bad_opcode;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
